// File: rtl/strip_frame_sequencer.sv
// Walks the frame memory one GRB word at a time, offers each word to the bit
// encoder, then holds the strip latch gap before reporting the frame done.
module strip_frame_sequencer #(
   parameter int LED_COUNT    = 60,
   parameter int ADDR_WIDTH   = 8,
   parameter int LATCH_CYCLES = 1000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  frame_start,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read_enable,
   input  logic [23:0]           mem_read_data,
   output logic [23:0]           encoder_data,
   output logic                  encoder_valid,
   input  logic                  encoder_ready,
   output logic                  strip_latch,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  frame_overrun
);

   localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(LED_COUNT - 1);
   localparam logic [15:0]           LATCH_LAST = 16'(LATCH_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_DATA,
      OFFER,
      DRAIN,
      LATCH
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] index;
   logic [ADDR_WIDTH-1:0] index_next;
   logic [15:0]           latch_count;
   logic [15:0]           latch_count_next;
   logic [ADDR_WIDTH-1:0] mem_addr_next;
   logic                  mem_read_enable_next;
   logic [23:0]           encoder_data_next;
   logic                  encoder_valid_next;
   logic                  strip_latch_next;
   logic                  busy_next;
   logic                  frame_done_next;
   logic                  frame_overrun_next;

   // Every output is registered from its next-state value so the encoder and
   // memory see clean, glitch-free strobes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         index           <= '0;
         latch_count     <= '0;
         mem_addr        <= '0;
         mem_read_enable <= 1'b0;
         encoder_data    <= '0;
         encoder_valid   <= 1'b0;
         strip_latch     <= 1'b0;
         busy            <= 1'b0;
         frame_done      <= 1'b0;
         frame_overrun   <= 1'b0;
      end else begin
         state           <= state_next;
         index           <= index_next;
         latch_count     <= latch_count_next;
         mem_addr        <= mem_addr_next;
         mem_read_enable <= mem_read_enable_next;
         encoder_data    <= encoder_data_next;
         encoder_valid   <= encoder_valid_next;
         strip_latch     <= strip_latch_next;
         busy            <= busy_next;
         frame_done      <= frame_done_next;
         frame_overrun   <= frame_overrun_next;
      end
   end

   always_comb begin
      state_next           = state;
      index_next           = index;
      latch_count_next     = latch_count;
      mem_addr_next        = mem_addr;
      mem_read_enable_next = 1'b0;
      encoder_data_next    = encoder_data;
      encoder_valid_next   = encoder_valid;
      strip_latch_next     = 1'b0;
      frame_done_next      = 1'b0;
      frame_overrun_next   = frame_start && (state != IDLE);

      case (state)
         IDLE: begin
            if (frame_start) begin
               state_next           = FETCH;
               index_next           = '0;
               mem_addr_next        = '0;
               mem_read_enable_next = 1'b1;
            end
         end
         FETCH: begin
            state_next = WAIT_DATA;
         end
         WAIT_DATA: begin
            encoder_data_next  = mem_read_data;
            encoder_valid_next = 1'b1;
            state_next         = OFFER;
         end
         OFFER: begin
            if (encoder_ready) begin
               encoder_valid_next = 1'b0;
               if (index == LAST_INDEX) begin
                  state_next = DRAIN;
               end else begin
                  index_next           = index + 1'b1;
                  mem_addr_next        = index + 1'b1;
                  mem_read_enable_next = 1'b1;
                  state_next           = FETCH;
               end
            end
         end
         DRAIN: begin
            // The last word is still shifting out until the encoder is ready again.
            if (encoder_ready) begin
               latch_count_next = '0;
               strip_latch_next = 1'b1;
               state_next       = LATCH;
            end
         end
         LATCH: begin
            if (latch_count == LATCH_LAST) begin
               frame_done_next = 1'b1;
               state_next      = IDLE;
            end else begin
               latch_count_next = latch_count + 16'd1;
               strip_latch_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

endmodule

// File: tb/tb_strip_frame_sequencer.sv
// Bench for strip_frame_sequencer: a 3-LED and a 1-LED build checked every cycle
// against a timeline model, plus directed scenarios with literal expectations.
module tb_strip_frame_sequencer;

   localparam int ADDR_WIDTH   = 8;
   localparam int LATCH_CYCLES = 4;
   localparam int LEDS [2]     = '{3, 1};

   logic                  clock = 1'b0;
   logic                  reset [2];
   logic                  frame_start [2];
   logic [ADDR_WIDTH-1:0] mem_addr [2];
   logic                  mem_read_enable [2];
   logic [23:0]           mem_read_data [2];
   logic [23:0]           encoder_data [2];
   logic                  encoder_valid [2];
   logic                  encoder_ready [2];
   logic                  strip_latch [2];
   logic                  busy [2];
   logic                  frame_done [2];
   logic                  frame_overrun [2];

   int checks = 0;
   int errors = 0;

   // Model: frame progress expressed as edge numbers of fetch launches and latch start.
   int                    m_edge = 0;
   bit                    m_known [2];
   bit                    m_active [2];
   bit                    m_fetching [2];
   bit                    m_draining [2];
   int                    m_word [2];
   int                    m_launch [2];
   int                    m_latch_start [2];
   logic [ADDR_WIDTH-1:0] m_addr [2];
   logic [23:0]           m_data [2];
   bit                    m_done [2];
   bit                    m_overrun [2];
   bit                    m_xfer [2];

   int                    ready_mode [2];
   int                    xfer_cnt [2];
   int                    read_cnt [2];
   int                    latch_cnt [2];
   int                    done_cnt [2];
   int                    overrun_cnt [2];
   logic [23:0]           last_xfer [2];
   logic [23:0]           xfer_q [$];
   logic [ADDR_WIDTH-1:0] addr_q [$];

   int n, hold, snap_a, snap_b, snap_c, snap_d;

   strip_frame_sequencer #(
      .LED_COUNT(3), .ADDR_WIDTH(ADDR_WIDTH), .LATCH_CYCLES(LATCH_CYCLES)
   ) dut0 (
      .clock(clock), .reset(reset[0]), .frame_start(frame_start[0]),
      .mem_addr(mem_addr[0]), .mem_read_enable(mem_read_enable[0]),
      .mem_read_data(mem_read_data[0]), .encoder_data(encoder_data[0]),
      .encoder_valid(encoder_valid[0]), .encoder_ready(encoder_ready[0]),
      .strip_latch(strip_latch[0]), .busy(busy[0]), .frame_done(frame_done[0]),
      .frame_overrun(frame_overrun[0])
   );

   strip_frame_sequencer #(
      .LED_COUNT(1), .ADDR_WIDTH(ADDR_WIDTH), .LATCH_CYCLES(LATCH_CYCLES)
   ) dut1 (
      .clock(clock), .reset(reset[1]), .frame_start(frame_start[1]),
      .mem_addr(mem_addr[1]), .mem_read_enable(mem_read_enable[1]),
      .mem_read_data(mem_read_data[1]), .encoder_data(encoder_data[1]),
      .encoder_valid(encoder_valid[1]), .encoder_ready(encoder_ready[1]),
      .strip_latch(strip_latch[1]), .busy(busy[1]), .frame_done(frame_done[1]),
      .frame_overrun(frame_overrun[1])
   );

   always #5 clock = ~clock;

   // Frame memory returns 800000+addr the cycle after a read, garbage otherwise.
   always @(posedge clock) begin
      for (int i = 0; i < 2; i++)
         mem_read_data[i] <= mem_read_enable[i] ? 24'h800000 + 24'(mem_addr[i]) : 24'($urandom);
   end

   task automatic checkOutput(input string name, input int inst,
                              input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s[%0d] actual=%h expected=%h at %0t", name, inst, actual, expected, $time);
      end
   endtask

   task automatic modelStep(input int i);
      m_xfer[i]    = 1'b0;
      m_done[i]    = 1'b0;
      m_overrun[i] = 1'b0;
      if (reset[i]) begin
         m_known[i]    = 1'b1;
         m_active[i]   = 1'b0;
         m_fetching[i] = 1'b0;
         m_draining[i] = 1'b0;
         m_addr[i]     = '0;
         m_data[i]     = '0;
      end else begin
         m_overrun[i] = frame_start[i] && m_active[i];
         if (!m_active[i]) begin
            if (frame_start[i]) begin
               m_active[i]   = 1'b1;
               m_fetching[i] = 1'b1;
               m_draining[i] = 1'b0;
               m_word[i]     = 0;
               m_launch[i]   = m_edge;
               m_addr[i]     = '0;
            end
         end else if (m_fetching[i]) begin
            if (m_edge == m_launch[i] + 2) begin
               m_data[i] = 24'h800000 + 24'(m_word[i]);
            end else if (m_edge >= m_launch[i] + 3 && encoder_ready[i]) begin
               m_xfer[i] = 1'b1;
               if (m_word[i] == LEDS[i] - 1) begin
                  m_fetching[i] = 1'b0;
                  m_draining[i] = 1'b1;
               end else begin
                  m_word[i]   = m_word[i] + 1;
                  m_launch[i] = m_edge;
                  m_addr[i]   = ADDR_WIDTH'(m_word[i]);
               end
            end
         end else if (m_draining[i]) begin
            if (encoder_ready[i]) begin
               m_draining[i]    = 1'b0;
               m_latch_start[i] = m_edge;
            end
         end else if (m_edge == m_latch_start[i] + LATCH_CYCLES) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b1;
         end
      end
   endtask

   always @(posedge clock) begin
      m_edge++;
      for (int i = 0; i < 2; i++) modelStep(i);
   end

   // Observation log of what the DUTs actually did, used by the directed checks.
   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (encoder_valid[i] === 1'b1 && encoder_ready[i] === 1'b1) begin
            xfer_cnt[i]++;
            last_xfer[i] = encoder_data[i];
            if (i == 0) xfer_q.push_back(encoder_data[0]);
         end
         if (mem_read_enable[i] === 1'b1) begin
            read_cnt[i]++;
            if (i == 0) addr_q.push_back(mem_addr[0]);
         end
         if (strip_latch[i] === 1'b1) latch_cnt[i]++;
         if (frame_done[i] === 1'b1) done_cnt[i]++;
         if (frame_overrun[i] === 1'b1) overrun_cnt[i]++;
      end
   end

   // Encoder stand-in: never ready in the cycle after it accepts a word.
   always @(negedge clock) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         if (m_xfer[i]) encoder_ready[i] = 1'b0;
         else if (ready_mode[i] == 0) encoder_ready[i] = 1'b1;
         else if (ready_mode[i] == 1) encoder_ready[i] = ($urandom_range(0, 2) != 0);
         else encoder_ready[i] = 1'b0;
      end
   end

   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (m_known[i]) begin
            checkOutput("mem_addr", i, 32'(mem_addr[i]), 32'(m_addr[i]));
            checkOutput("mem_read_enable", i, 32'(mem_read_enable[i]),
                        32'(m_active[i] && m_fetching[i] && m_edge == m_launch[i]));
            checkOutput("encoder_valid", i, 32'(encoder_valid[i]),
                        32'(m_active[i] && m_fetching[i] && m_edge >= m_launch[i] + 2));
            checkOutput("encoder_data", i, 32'(encoder_data[i]), 32'(m_data[i]));
            checkOutput("strip_latch", i, 32'(strip_latch[i]),
                        32'(m_active[i] && !m_fetching[i] && !m_draining[i]));
            checkOutput("busy", i, 32'(busy[i]), 32'(m_active[i]));
            checkOutput("frame_done", i, 32'(frame_done[i]), 32'(m_done[i]));
            checkOutput("frame_overrun", i, 32'(frame_overrun[i]), 32'(m_overrun[i]));
         end
      end
   end

   task automatic applyStimulus(input int i, input bit start, input bit rst);
      frame_start[i] = start;
      reset[i]       = rst;
      @(negedge clock);
      frame_start[i] = 1'b0;
      reset[i]       = 1'b0;
   endtask

   task automatic waitIdle(input int i);
      int k = 0;
      while (busy[i] !== 1'b0 && k < 500) begin
         @(negedge clock);
         k++;
      end
      checkOutput("idle_timeout", i, 32'(busy[i]), 32'd0);
      repeat (2) @(negedge clock);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         reset[i]       = 1'b1;
         frame_start[i] = 1'b0;
         ready_mode[i]  = 0;
      end
      repeat (3) @(negedge clock);
      reset[0] = 1'b0;
      reset[1] = 1'b0;
      checkOutput("reset_busy", 0, 32'(busy[0]), 32'd0);
      checkOutput("reset_valid", 0, 32'(encoder_valid[0]), 32'd0);

      $display("[TB] basic frame");
      xfer_q.delete();
      addr_q.delete();
      snap_a = latch_cnt[0];
      snap_b = done_cnt[0];
      applyStimulus(0, 1'b1, 1'b0);
      checkOutput("lat_read", 0, 32'(mem_read_enable[0]), 32'd1);
      checkOutput("lat_addr", 0, 32'(mem_addr[0]), 32'd0);
      repeat (2) @(negedge clock);
      checkOutput("lat_valid", 0, 32'(encoder_valid[0]), 32'd1);
      checkOutput("lat_data", 0, 32'(encoder_data[0]), 32'h800000);
      waitIdle(0);
      checkOutput("basic_xfers", 0, 32'(xfer_q.size()), 32'd3);
      for (int k = 0; k < 3; k++) begin
         checkOutput("basic_data", 0, (k < xfer_q.size()) ? 32'(xfer_q[k]) : 32'hFFFFFFFF,
                     32'h800000 + 32'(k));
         checkOutput("basic_addr", 0, (k < addr_q.size()) ? 32'(addr_q[k]) : 32'hFFFFFFFF, 32'(k));
      end
      checkOutput("basic_latch_len", 0, 32'(latch_cnt[0] - snap_a), 32'd4);
      checkOutput("basic_done", 0, 32'(done_cnt[0] - snap_b), 32'd1);
      checkOutput("basic_busy_after", 0, 32'(busy[0]), 32'd0);

      $display("[TB] backpressure");
      applyStimulus(0, 1'b1, 1'b0);
      n = 0;
      while (!(m_fetching[0] && m_word[0] == 1 && m_edge >= m_launch[0] + 2) && n < 100) begin
         @(negedge clock);
         n++;
      end
      checkOutput("bp_reach_word1", 0, 32'(n < 100), 32'd1);
      ready_mode[0] = 2;
      snap_a = read_cnt[0];
      hold = 0;
      repeat (20) begin
         if (encoder_valid[0] === 1'b1 && encoder_data[0] === 24'h800001) hold++;
         @(negedge clock);
      end
      ready_mode[0] = 0;
      checkOutput("bp_hold_cycles", 0, 32'(hold), 32'd20);
      checkOutput("bp_no_extra_read", 0, 32'(read_cnt[0] - snap_a), 32'd0);
      waitIdle(0);

      $display("[TB] overrun");
      ready_mode[0] = 1;
      snap_a = overrun_cnt[0];
      snap_b = xfer_cnt[0];
      xfer_q.delete();
      applyStimulus(0, 1'b1, 1'b0);
      n = 0;
      while (!(m_fetching[0] && m_edge >= m_launch[0] + 2) && n < 100) begin
         @(negedge clock);
         n++;
      end
      applyStimulus(0, 1'b1, 1'b0);
      checkOutput("ovr_pulse", 0, 32'(frame_overrun[0]), 32'd1);
      waitIdle(0);
      ready_mode[0] = 0;
      checkOutput("ovr_count", 0, 32'(overrun_cnt[0] - snap_a), 32'd1);
      checkOutput("ovr_xfers", 0, 32'(xfer_cnt[0] - snap_b), 32'd3);
      checkOutput("ovr_last_data", 0, (xfer_q.size() == 3) ? 32'(xfer_q[2]) : 32'hFFFFFFFF, 32'h800002);

      $display("[TB] back-to-back");
      snap_a = overrun_cnt[0];
      snap_b = done_cnt[0];
      applyStimulus(0, 1'b1, 1'b0);
      n = 0;
      while (frame_done[0] !== 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      checkOutput("b2b_done_seen", 0, 32'(frame_done[0]), 32'd1);
      applyStimulus(0, 1'b1, 1'b0);
      checkOutput("b2b_read", 0, 32'(mem_read_enable[0]), 32'd1);
      checkOutput("b2b_addr", 0, 32'(mem_addr[0]), 32'd0);
      checkOutput("b2b_no_overrun", 0, 32'(frame_overrun[0]), 32'd0);
      waitIdle(0);
      checkOutput("b2b_overruns", 0, 32'(overrun_cnt[0] - snap_a), 32'd0);
      checkOutput("b2b_dones", 0, 32'(done_cnt[0] - snap_b), 32'd2);

      $display("[TB] reset mid-frame");
      snap_a = done_cnt[0];
      applyStimulus(0, 1'b1, 1'b0);
      n = 0;
      while (!(m_fetching[0] && m_word[0] == 2 && m_edge == m_launch[0] + 1) && n < 100) begin
         @(negedge clock);
         n++;
      end
      checkOutput("rst_reach_word2", 0, 32'(n < 100), 32'd1);
      applyStimulus(0, 1'b0, 1'b1);
      checkOutput("rst_valid", 0, 32'(encoder_valid[0]), 32'd0);
      checkOutput("rst_busy", 0, 32'(busy[0]), 32'd0);
      checkOutput("rst_data", 0, 32'(encoder_data[0]), 32'd0);
      checkOutput("rst_addr", 0, 32'(mem_addr[0]), 32'd0);
      repeat (10) @(negedge clock);
      checkOutput("rst_no_done", 0, 32'(done_cnt[0] - snap_a), 32'd0);
      applyStimulus(0, 1'b1, 1'b0);
      checkOutput("rst_restart_read", 0, 32'(mem_read_enable[0]), 32'd1);
      checkOutput("rst_restart_addr", 0, 32'(mem_addr[0]), 32'd0);
      waitIdle(0);

      $display("[TB] single LED");
      snap_a = xfer_cnt[1];
      snap_b = latch_cnt[1];
      snap_c = done_cnt[1];
      snap_d = read_cnt[1];
      applyStimulus(1, 1'b1, 1'b0);
      waitIdle(1);
      checkOutput("one_xfers", 1, 32'(xfer_cnt[1] - snap_a), 32'd1);
      checkOutput("one_data", 1, 32'(last_xfer[1]), 32'h800000);
      checkOutput("one_reads", 1, 32'(read_cnt[1] - snap_d), 32'd1);
      checkOutput("one_latch_len", 1, 32'(latch_cnt[1] - snap_b), 32'd4);
      checkOutput("one_done", 1, 32'(done_cnt[1] - snap_c), 32'd1);

      $display("[TB] random traffic");
      for (int c = 0; c < 3000; c++) begin
         if (c % 100 == 0) begin
            ready_mode[0] = int'($urandom_range(0, 1));
            ready_mode[1] = int'($urandom_range(0, 1));
         end
         for (int i = 0; i < 2; i++) begin
            frame_start[i] = ($urandom_range(0, 19) == 0);
            reset[i]       = ($urandom_range(0, 299) == 0);
         end
         @(negedge clock);
      end
      for (int i = 0; i < 2; i++) begin
         frame_start[i] = 1'b0;
         reset[i]       = 1'b0;
         ready_mode[i]  = 0;
      end
      waitIdle(0);
      waitIdle(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/strip_frame_sequencer.md
STRIP_FRAME_SEQUENCER -- requirements
Module: strip_frame_sequencer

Interface
REQ-001 Parameters SHALL be: LED_COUNT, 60, LEDs per strip (range 1..256); ADDR_WIDTH, 8, frame-memory address width; LATCH_CYCLES, 1000, clocks of latch/reset gap after the last word (range 1..65535).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clock  in  1  bit-segment clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse requesting a frame
- mem_addr  out  ADDR_WIDTH  frame-memory read address
- mem_read_enable  out  1  read strobe; data valid the following cycle
- mem_read_data  in  24  GRB word from memory
- encoder_data  out  24  word offered to the encoder
- encoder_valid  out  1  encoder_data valid
- encoder_ready  in  1  encoder idle and able to accept
- strip_latch  out  1  high during the latch gap; drives the encoder reset
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at frame end
- frame_overrun  out  1  one-cycle pulse when frame_start is dropped

Function
REQ-003 The state machine SHALL have states IDLE, FETCH, WAIT_DATA, OFFER, DRAIN and LATCH; all outputs SHALL be registered.
REQ-004 IDLE SHALL move to FETCH on frame_start=1 and clear the LED index to 0; otherwise it SHALL hold.
REQ-005 FETCH SHALL assert mem_read_enable=1 with mem_addr=index for exactly one cycle, then go to WAIT_DATA.
REQ-006 WAIT_DATA SHALL capture mem_read_data into encoder_data, then go to OFFER.
REQ-007 OFFER SHALL hold encoder_valid=1 with encoder_data stable until encoder_ready=1 (transfer).
REQ-008 On a transfer, OFFER SHALL clear encoder_valid and then:
- if index < LED_COUNT-1: increment index, go to FETCH;
- if index = LED_COUNT-1: go to DRAIN.
REQ-009 Encoder contract: encoder_ready SHALL be low in the cycle after an accepted transfer and SHALL return high when its last bit has been shifted out.
REQ-010 DRAIN SHALL wait for encoder_ready=1, then go to LATCH with the latch counter at 0.
REQ-011 LATCH SHALL hold strip_latch=1 for exactly LATCH_CYCLES cycles, then go to IDLE.
REQ-012 frame_done SHALL pulse high in the first IDLE cycle after LATCH.
REQ-013 Latency: with frame_start sampled at edge N, mem_read_enable SHALL be high in cycle N+1 and encoder_valid high from cycle N+3.
REQ-014 Between consecutive words the minimum spacing SHALL be 3 cycles from transfer to the next encoder_valid.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 frame_start while busy=1 SHALL be ignored, with frame_overrun=1 in the next cycle; frame_start in the first IDLE cycle (the frame_done cycle) SHALL be accepted.
REQ-017 The index SHALL never exceed LED_COUNT-1, and mem_addr SHALL never wrap.
REQ-018 With LED_COUNT=1 the block SHALL go directly from OFFER to DRAIN after one transfer.
REQ-019 Counter widths:
- index: ADDR_WIDTH bits;
- latch counter: 16 bits, compared against LATCH_CYCLES-1.

Reset
REQ-020 While reset=1 at an edge, the block SHALL enter IDLE and set index and latch counter to 0, and mem_addr, mem_read_enable, encoder_data, encoder_valid, strip_latch, busy, frame_done and frame_overrun to 0.
REQ-021 reset SHALL take priority over frame_start in the same cycle.
REQ-022 Reset in any state mid-frame SHALL abort the frame with no frame_done pulse, and encoder_valid SHALL be 0 in the following cycle.

Verification (LED_COUNT=3, LATCH_CYCLES=4, memory returns 24'h800000+addr)
REQ-023 Basic frame:
- stimulus: frame_start at edge 10, encoder_ready always 1 except low for one cycle after each transfer;
- response: mem_addr 0,1,2 in order; encoder_data 800000, 800001, 800002; strip_latch high 4 cycles; one frame_done; busy low afterwards.
REQ-024 Backpressure:
- stimulus: encoder_ready held low 20 cycles during the OFFER of word 1;
- response: encoder_data stays 800001 with encoder_valid=1 all 20 cycles; no extra memory read.
REQ-025 Overrun:
- stimulus: frame_start during OFFER;
- response: frame_overrun pulses once; index and sequence unaffected; exactly 3 transfers.
REQ-026 Back-to-back frames:
- stimulus: frame_start coincident with the frame_done cycle;
- response: new frame begins, mem_read_enable high the next cycle with mem_addr=0; no frame_overrun.
REQ-027 Reset mid-frame:
- stimulus: reset during WAIT_DATA of word 2;
- response: all outputs 0 next cycle; no frame_done; a subsequent frame_start restarts at mem_addr=0.
REQ-028 Single LED:
- stimulus: LED_COUNT=1 build, frame_start;
- response: one transfer of 800000, DRAIN, 4-cycle latch, frame_done.
